// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// Optional ALU_ARB_LOCK_EN adds a lock input for back-to-back carry chains.
module alu_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 32,
    parameter int OPCODE      = 4,
    parameter int REGS_CODING = 3,
    parameter int FLAGS       = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*OPCODE-1:0]        req_opcode,
    input  logic [NREQ*WIDTH-1:0]         req_op1,
    input  logic [NREQ*WIDTH-1:0]         req_op2,
    input  logic [NREQ-1:0]               req_cin,
    input  logic [NREQ*REGS_CODING-1:0]   req_dest,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NREQ-1:0]               lock,
`endif
    output logic [NREQ-1:0]               ack,
    output logic [WIDTH-1:0]              rsp_result,
    output logic [FLAGS-1:0]              rsp_flags,
    output logic [REGS_CODING-1:0]        rsp_dest,
    output logic                          busy,
    output logic                          alu_en,
    output logic [OPCODE-1:0]             alu_opcode,
    output logic [WIDTH-1:0]              alu_op1,
    output logic [WIDTH-1:0]              alu_op2,
    output logic                          alu_cin,
    output logic [REGS_CODING-1:0]        alu_dest,
    input  logic [WIDTH-1:0]              alu_result,
    input  logic [FLAGS-1:0]              alu_flags,
    input  logic [REGS_CODING-1:0]        alu_dest_out
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t                 state, state_d;
    logic [PW-1:0]          ptr, ptr_d;
    logic [PW-1:0]          grant, grant_d;
    logic [PW-1:0]          sel;
    logic [NREQ-1:0]        ack_d;
    logic                   busy_d, alu_en_d, alu_cin_d;
    logic [OPCODE-1:0]      alu_opcode_d;
    logic [WIDTH-1:0]       alu_op1_d, alu_op2_d, rsp_result_d;
    logic [REGS_CODING-1:0] alu_dest_d, rsp_dest_d;
    logic [FLAGS-1:0]       rsp_flags_d;
`ifdef ALU_ARB_LOCK_EN
    logic                   lock_hold, lock_hold_d;
    logic [2:0]             lock_cnt, lock_cnt_d;
`endif

    // First requester at or after p, wrapping around
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [PW-1:0] p);
        logic [PW-1:0] w;
        logic          hit;
        w   = p;
        hit = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(p) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!hit && r[j]) begin
                hit = 1'b1;
                w   = PW'(j);
            end
        end
        return w;
    endfunction

    // Winner selection, with optional lock re-grant
    always_comb begin
        sel = rr_pick(req, ptr);
`ifdef ALU_ARB_LOCK_EN
        if (lock_hold && req[grant]) sel = grant;
`endif
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state;
        ptr_d        = ptr;
        grant_d      = grant;
        ack_d        = '0;
        busy_d       = busy;
        alu_en_d     = 1'b0;
        alu_opcode_d = alu_opcode;
        alu_op1_d    = alu_op1;
        alu_op2_d    = alu_op2;
        alu_cin_d    = alu_cin;
        alu_dest_d   = alu_dest;
        rsp_result_d = rsp_result;
        rsp_flags_d  = rsp_flags;
        rsp_dest_d   = rsp_dest;
`ifdef ALU_ARB_LOCK_EN
        lock_hold_d  = lock_hold;
        lock_cnt_d   = lock_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (|req) begin
                    grant_d      = sel;
                    alu_opcode_d = req_opcode[int'(sel)*OPCODE +: OPCODE];
                    alu_op1_d    = req_op1[int'(sel)*WIDTH +: WIDTH];
                    alu_op2_d    = req_op2[int'(sel)*WIDTH +: WIDTH];
                    alu_cin_d    = req_cin[sel];
                    alu_dest_d   = req_dest[int'(sel)*REGS_CODING +: REGS_CODING];
                    alu_en_d     = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ISSUE;
`ifdef ALU_ARB_LOCK_EN
                    lock_hold_d  = 1'b0;
`endif
                end
            end
            ISSUE: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                rsp_dest_d   = alu_dest_out;
                ack_d[grant] = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                ptr_d   = (grant == PW'(NREQ - 1)) ? '0 : grant + PW'(1);
`ifdef ALU_ARB_LOCK_EN
                if (lock[grant] && req[grant] && lock_cnt != 3'd7) begin
                    lock_hold_d = 1'b1;
                    lock_cnt_d  = lock_cnt + 3'd1;
                    ptr_d       = ptr;
                end else begin
                    lock_hold_d = 1'b0;
                    lock_cnt_d  = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            grant      <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            alu_en     <= 1'b0;
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_cin    <= 1'b0;
            alu_dest   <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_dest   <= '0;
`ifdef ALU_ARB_LOCK_EN
            lock_hold  <= 1'b0;
            lock_cnt   <= '0;
`endif
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            grant      <= grant_d;
            ack        <= ack_d;
            busy       <= busy_d;
            alu_en     <= alu_en_d;
            alu_opcode <= alu_opcode_d;
            alu_op1    <= alu_op1_d;
            alu_op2    <= alu_op2_d;
            alu_cin    <= alu_cin_d;
            alu_dest   <= alu_dest_d;
            rsp_result <= rsp_result_d;
            rsp_flags  <= rsp_flags_d;
            rsp_dest   <= rsp_dest_d;
`ifdef ALU_ARB_LOCK_EN
            lock_hold  <= lock_hold_d;
            lock_cnt   <= lock_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a negedge ALU model.
// Lock scenario runs only when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;

    localparam int N = 4;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic [3:0]  fl;
        logic [2:0]  dst;
    } exp_t;

    logic          clk, reset;
    logic [N-1:0]  req, req_cin, ack;
    logic [N*4-1:0]  req_opcode;
    logic [N*32-1:0] req_op1, req_op2;
    logic [N*3-1:0]  req_dest;
    logic [31:0]   rsp_result, alu_op1, alu_op2, alu_result;
    logic [3:0]    rsp_flags, alu_opcode, alu_flags;
    logic [2:0]    rsp_dest, alu_dest, alu_dest_out;
    logic          busy, alu_en, alu_cin;
`ifdef ALU_ARB_LOCK_EN
    logic [N-1:0]  lock;
`endif

    exp_t exp_q[$];
    int   checks, passes, m_ptr;
    int   ackcnt[N];
    logic [N-1:0] keep;
    logic [3:0]  s_op[N];
    logic [31:0] s_a[N], s_b[N];
    logic        s_c[N];
    logic [2:0]  s_d[N];

    alu_arbiter dut (
        .clk(clk), .reset(reset), .req(req),
        .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
        .req_cin(req_cin), .req_dest(req_dest),
`ifdef ALU_ARB_LOCK_EN
        .lock(lock),
`endif
        .ack(ack), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_dest(rsp_dest), .busy(busy), .alu_en(alu_en),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_cin(alu_cin), .alu_dest(alu_dest), .alu_result(alu_result),
        .alu_flags(alu_flags), .alu_dest_out(alu_dest_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: {flags, result}
    function automatic logic [35:0] alu_f(input logic [3:0] op,
                                          input logic [31:0] a, b,
                                          input logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        c = 1'b0;
        s = '0;
        case (op)
            4'h0: begin s = {1'b0, a} + {1'b0, b} + 33'(cin); r = s[31:0]; c = s[32]; end
            4'h1: begin s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = s[32]; end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'hD: begin s = {1'b0, a} + 33'd1; r = s[31:0]; c = s[32]; end
            default: r = a ^ {b[15:0], b[31:16]};
        endcase
        return {r == 32'd0, r[31], c, ^op, r};
    endfunction

    // ALU instance model: registers outputs on the falling edge
    initial begin
        alu_result = '0;
        alu_flags = '0;
        alu_dest_out = '0;
        forever begin
            @(negedge clk);
            if (alu_en) begin
                {alu_flags, alu_result} = alu_f(alu_opcode, alu_op1, alu_op2, alu_cin);
                alu_dest_out = alu_dest;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: pops the scoreboard on every ack
    initial begin
        logic prev_en;
        exp_t e;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (alu_en) chk("alu_en_one_cycle", 64'(prev_en), 64'd0);
                if (ack != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("ack_unexpected", 64'(ack), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_onehot", 64'(ack), 64'(1) << e.idx);
                        chk("rsp_result", 64'(rsp_result), 64'(e.res));
                        chk("rsp_flags", 64'(rsp_flags), 64'(e.fl));
                        chk("rsp_dest", 64'(rsp_dest), 64'(e.dst));
                        chk("ack_latency", 64'({prev_en, alu_en}), 64'b10);
                    end
                end
            end
            prev_en = reset ? 1'b0 : alu_en;
        end
    end

    // One cycle; requesters drop req once acked unless held
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                ackcnt[i]++;
                if (!keep[i]) req[i] = 1'b0;
            end
        end
    endtask

    task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic c, input logic [2:0] d);
        s_op[i] = op; s_a[i] = a; s_b[i] = b; s_c[i] = c; s_d[i] = d;
        req_opcode[i*4 +: 4] = op;
        req_op1[i*32 +: 32] = a;
        req_op2[i*32 +: 32] = b;
        req_cin[i] = c;
        req_dest[i*3 +: 3] = d;
        req[i] = 1'b1;
    endtask

    task automatic issue_rand(input int i);
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        issue(i, op, $urandom, $urandom, 1'($urandom), 3'($urandom));
    endtask

    task automatic expect_op(input int i);
        logic [35:0] r;
        exp_t e;
        r = alu_f(s_op[i], s_a[i], s_b[i], s_c[i]);
        e.idx = i; e.res = r[31:0]; e.fl = r[35:32]; e.dst = s_d[i];
        exp_q.push_back(e);
        m_ptr = (i + 1) % N;
    endtask

    // Round-robin service order for a set of simultaneous requests
    task automatic plan(input logic [N-1:0] mask);
        logic [N-1:0] p;
        int w;
        p = mask;
        while (p != '0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && p[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            expect_op(w);
            p[w] = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req != '0 || busy || ack != '0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < 200), 64'd1);
        tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_busy", 64'({busy, alu_en}), 64'd0);
    endtask

    task automatic wait_en();
        int n;
        n = 0;
        while (!alu_en && n < 20) begin
            tick();
            n++;
        end
        chk("alu_en_seen", 64'(alu_en), 64'd1);
    endtask

    task automatic wait_acks(input int i, input int target);
        int n;
        n = 0;
        while (ackcnt[i] < target && n < 200) begin
            tick();
            n++;
        end
        chk("ack_count_timeout", 64'(ackcnt[i] >= target), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_ptr = 0;
    endtask

    initial begin
        int base;
        logic [N-1:0] mask;
        checks = 0; passes = 0; m_ptr = 0; keep = '0;
        for (int i = 0; i < N; i++) ackcnt[i] = 0;
        reset = 1'b1;
        req = '0; req_cin = '0; req_opcode = '0;
        req_op1 = '0; req_op2 = '0; req_dest = '0;
`ifdef ALU_ARB_LOCK_EN
        lock = '0;
`endif
        tick();
        tick();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_busy_en", 64'({busy, alu_en}), 64'd0);
        chk("rst_rsp", 64'({rsp_result, rsp_flags, rsp_dest}), 64'd0);
        chk("rst_alu_ops", 64'({alu_opcode, alu_op1, alu_cin, alu_dest}), 64'd0);
        chk("rst_alu_op2", 64'(alu_op2), 64'd0);
        reset = 1'b0;

        // Single add request
        issue(0, 4'h0, 32'd5, 32'd7, 1'b0, 3'd3);
        expect_op(0);
        drain();
        chk("single_result", 64'(rsp_result), 64'd12);
        chk("single_dest", 64'(rsp_dest), 64'd3);

        // All four at once from reset
        do_reset();
        for (int i = 0; i < N; i++) issue_rand(i);
        plan(4'hF);
        drain();

        // Requester 2 held while requester 1 joins
        base = ackcnt[2];
        keep[2] = 1'b1;
        issue_rand(2);
        expect_op(2);
        wait_en();
        issue_rand(1);
        expect_op(1);
        expect_op(2);
        wait_acks(2, base + 2);
        keep[2] = 1'b0;
        req[2] = 1'b0;
        drain();

        // Drop req and change operands after grant
        issue(0, 4'hD, 32'hFFFF_FFFF, $urandom, 1'b0, 3'd5);
        expect_op(0);
        wait_en();
        req[0] = 1'b0;
        req_op1[31:0] = 32'h1234;
        req_opcode[3:0] = 4'h2;
        drain();
        chk("drop_result", 64'(rsp_result), 64'd0);

        // Reset in the middle of an operation
        issue_rand(1);
        wait_en();
        reset = 1'b1;
        #1;
        chk("midrst_en", 64'({alu_en, busy}), 64'd0);
        chk("midrst_ack", 64'(ack), 64'd0);
        req = '0;
        tick();
        tick();
        reset = 1'b0;
        m_ptr = 0;
        issue_rand(0);
        issue_rand(3);
        plan(4'b1001);
        drain();

        // Randomised simultaneous request sets
        for (int r = 0; r < 40; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) if (mask[i]) issue_rand(i);
            plan(mask);
            drain();
        end

`ifdef ALU_ARB_LOCK_EN
        // Lock chain on requester 0 with requester 1 waiting
        do_reset();
        base = ackcnt[0];
        keep[0] = 1'b1;
        lock[0] = 1'b1;
        issue_rand(0);
        issue_rand(1);
        for (int k = 0; k < 8; k++) expect_op(0);
        expect_op(1);
        wait_acks(0, base + 8);
        keep[0] = 1'b0;
        req[0] = 1'b0;
        lock = '0;
        drain();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one alu instance between NREQ requesters (core sequencers, address unit, debug port).
- Arbitrates round-robin, registers the winner's operands, drives the ALU enable for exactly one cycle, captures result/flags/dest, and returns them with a one-hot ack.
- Sits between the requesters and the ALU. The ALU registers its outputs on the falling edge inside the issue cycle.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- OPCODE, 4, ALU opcode width
- REGS_CODING, 3, destination register code width
- FLAGS, 4, ALU flag vector width

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high
- req  in  NREQ  per-requester request, held until ack
- req_opcode  in  NREQ*OPCODE  packed opcodes, requester i at [i*OPCODE +: OPCODE]
- req_op1  in  NREQ*WIDTH  packed operand 1
- req_op2  in  NREQ*WIDTH  packed operand 2
- req_cin  in  NREQ  per-requester carry in
- req_dest  in  NREQ*REGS_CODING  packed destination codes
- ack  out  NREQ  one-hot, 1-cycle pulse: result for requester i valid
- rsp_result  out  WIDTH  captured ALU result
- rsp_flags  out  FLAGS  captured ALU flags
- rsp_dest  out  REGS_CODING  captured ALU dest_out
- busy  out  1  high in ISSUE and DONE
- alu_en  out  1  ALU enable
- alu_opcode  out  OPCODE  to ALU
- alu_op1, alu_op2  out  WIDTH  to ALU
- alu_cin  out  1  to ALU
- alu_dest  out  REGS_CODING  to ALU dest_in
- alu_result  in  WIDTH  from ALU
- alu_flags  in  FLAGS  from ALU
- alu_dest_out  in  REGS_CODING  from ALU

Behaviour:
- Reset (async) forces the following; all alu_* operand outputs are registers.
  - state=IDLE, ptr=0, grant=0, ack=0, busy=0, alu_en=0.
  - rsp_*=0 and all alu_* outputs=0.
- FSM states IDLE, ISSUE, DONE.
  - IDLE: if any req, pick the first set bit searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
    - Latch the winner's opcode/op1/op2/cin/dest into the alu_* registers.
    - grant=winner, alu_en<=1, go to ISSUE.
  - ISSUE: one cycle, alu_en=1. The ALU computes on this cycle's negedge.
    - At the next posedge: alu_en<=0, capture alu_result/alu_flags/alu_dest_out into rsp_*, ack[grant]<=1, go to DONE.
  - DONE: one cycle, ack high; ptr<=(grant+1) mod NREQ; go to IDLE (ack<=0).
- Latency: req sampled in IDLE at edge N gives ack high during cycle N+2. Throughput is one op per 3 cycles.
- rsp_* hold their value until the next capture.
- Operands are latched at grant; requester changes after grant are ignored.
- Dropping req after grant does not abort: the op completes and ack still pulses.
- A requester must deassert req in the cycle after ack or it is re-queued. Because ptr moves past it, other pending requesters win first.
- Simultaneous requests: strict round-robin by ptr; no requester waits more than NREQ-1 operations.
- No req in IDLE: stay IDLE, all outputs stable, alu_en=0.
- Reset mid-ISSUE/DONE: the operation is discarded, no ack, ALU disabled immediately.
- ptr wraps NREQ-1 to 0.
- The ALU's flag semantics are not interpreted; flags are passed through unchanged.

Optional Feature:
- Macro ALU_ARB_LOCK_EN.
- Defined:
  - Extra input port lock (NREQ).
  - If lock[grant] is high in DONE and req[grant] is high, the next IDLE arbitration grants the same requester, skipping ptr search, and ptr is not advanced. This allows back-to-back add-with-carry / sub-with-carry chains without interleaving.
  - Lock is honoured for at most 8 consecutive ops (3-bit counter), then normal round-robin resumes.
- Undefined: no lock port; pure round-robin as above.

Test Plan:
- Reset then single request: req=0001, op=0000 (add), op1=5, op2=7, dest=3 -> alu_en high one cycle, ack=0001 two cycles after grant, rsp_result=12, rsp_dest=3, busy low after.
- All four request at once from reset -> grants in order 0,1,2,3, each ack 3 cycles apart, ptr back to 0.
- Requester 2 alone repeatedly while requester 1 joins -> after op for 2, requester 1 wins (ptr=3 wraps to 0, then 1), no starvation.
- req dropped during ISSUE (op=1101, op1=0xFFFFFFFF) -> ack still pulses, rsp_result=0; operand change after grant has no effect.
- reset asserted during ISSUE -> no ack, alu_en=0 immediately, ptr=0, next request served normally.
- ALU_ARB_LOCK_EN defined: requester 0 locked, 10 back-to-back reqs, requester 1 pending -> 8 consecutive grants to 0, then 1 granted.
